shared_dram_responder: RTL

Responder end of the core-to-data-memory interface in the four-core processor. It accepts read and write requests from the four processor cores over a req/ack handshake, serialises them through an arbiter onto one single-port data memory array, and returns read data and acknowledges to the requesting core. It sits between the core array and the data storage in the top level.

---
 rtl/shared_dram_responder_pkg.sv | 17 +
 rtl/shared_dram_responder_if.sv | 31 +++
 rtl/shared_dram_responder_rr_arbiter.sv | 41 ++++
 rtl/shared_dram_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/shared_dram_responder_pkg.sv
// Shared types and defaults for the shared data-memory responder.
// Optional feature macro: ARB_ROUND_ROBIN_EN (rotating arbitration).
package dram_resp_pkg;

    localparam int NCORES_DEF = 4;
    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] core_idx_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/shared_dram_responder_if.sv
// Core-side request/response bundle of the shared data memory.
// master = core array, slave = responder.
interface shared_dram_responder_if
    import dram_resp_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [NCORES-1:0]        req;
    logic [NCORES-1:0]        we;
    logic [NCORES*ADDR_W-1:0] addr;
    logic [NCORES*DATA_W-1:0] wdata;
    logic [NCORES-1:0]        end_core;
    logic [NCORES-1:0]        ack;
    logic [NCORES*DATA_W-1:0] rdata;
    logic                     busy;
    core_idx_t                grant_id;

    modport master (
        output req, we, addr, wdata, end_core,
        input  ack, rdata, busy, grant_id
    );

    modport slave (
        input  req, we, addr, wdata, end_core,
        output ack, rdata, busy, grant_id
    );

endinterface

// File: rtl/shared_dram_responder_rr_arbiter.sv
// Combinational request arbiter: rotating search from i_ptr when
// ARB_ROUND_ROBIN_EN is defined, otherwise lowest index wins.
module rr_arbiter
    import dram_resp_pkg::*;
#(
    parameter int NCORES = NCORES_DEF
) (
    input  logic [NCORES-1:0] i_eligible,
`ifdef ARB_ROUND_ROBIN_EN
    input  core_idx_t         i_ptr,
`endif
    output logic [NCORES-1:0] o_grant,
    output core_idx_t         o_idx
);

    logic      w_found;
    core_idx_t w_cand;

    // First eligible core in search order wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NCORES; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_cand = core_idx_t'((int'(i_ptr) + k) % NCORES);
`else
            w_cand = core_idx_t'(k);
`endif
            if (i_eligible[w_cand] && !w_found) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/shared_dram_responder.sv
// Serialises four cores' read/write requests onto one single-port memory.
// Optional feature macro: ARB_ROUND_ROBIN_EN (rotating arbitration).
module shared_dram_responder
    import dram_resp_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    shared_dram_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e                   r_state;
    state_e                   w_next_state;
    logic [NCORES-1:0]        w_eligible;
    logic [NCORES-1:0]        w_grant;
    core_idx_t                w_gnt_idx;
    core_idx_t                r_grant_id;
    logic                     r_we;
    logic [IDX_W-1:0]         r_idx;
    logic [DATA_W-1:0]        r_wdata;
    logic [NCORES-1:0]        r_ack;
    logic [NCORES*DATA_W-1:0] r_rdata;
    logic                     r_busy;
    logic [DATA_W-1:0]        r_mem [DEPTH];

    assign w_eligible = bus.req & ~bus.end_core;

`ifdef ARB_ROUND_ROBIN_EN
    core_idx_t r_rr_ptr;

    // Search start moves past the winner on every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == S_IDLE && |w_grant) begin
            r_rr_ptr <= core_idx_t'((int'(w_gnt_idx) + 1) % NCORES);
        end
    end
`endif

    rr_arbiter #(.NCORES(NCORES)) u_arb (
        .i_eligible (w_eligible),
`ifdef ARB_ROUND_ROBIN_EN
        .i_ptr      (r_rr_ptr),
`endif
        .o_grant    (w_grant),
        .o_idx      (w_gnt_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (|w_grant) begin
                    w_next_state = S_ACCESS;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Request latch plus registered ack/rdata/busy/grant_id
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id <= '0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_busy <= (w_next_state != S_IDLE);
            if (r_state == S_IDLE && |w_grant) begin
                r_grant_id <= w_gnt_idx;
                r_we       <= bus.we[w_gnt_idx];
                r_idx      <= bus.addr[int'(w_gnt_idx)*ADDR_W +: IDX_W];
                r_wdata    <= bus.wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
            end
            // ack lands in RESP; only the served core's rdata slice moves
            if (r_state == S_ACCESS) begin
                r_ack[r_grant_id] <= 1'b1;
                if (!r_we) begin
                    r_rdata[int'(r_grant_id)*DATA_W +: DATA_W] <= r_mem[r_idx];
                end
            end
        end
    end

    // Storage is not reset; reset on the edge leaving ACCESS drops the write
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_ACCESS && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
    assign bus.busy     = r_busy;
    assign bus.grant_id = r_grant_id;

endmodule
